// File: rtl/cword_pkg.sv
// Shared definitions for the microcode sequencer: control-word field map,
// sequencer states and the default idle word.
package cword_pkg;

    localparam int OUTCTL_LSB       = 0;
    localparam int OUTCTL_W         = 4;
    localparam int LOADCTL_LSB      = 4;
    localparam int LOADCTL_W        = 4;
    localparam int ALU_ARG_L_LSB    = 8;
    localparam int ALU_ARG_L_W      = 2;
    localparam int ALU_ARG_R_LSB    = 10;
    localparam int ALU_ARG_R_W      = 3;
    localparam int ALU_ALT_BIT      = 13;
    localparam int FLAGS_CALC_BIT   = 14;
    localparam int CARRY_BIT        = 15;
    localparam int ADDROUTCTL_LSB   = 16;
    localparam int ADDROUTCTL_W     = 3;
    localparam int ADDRLOADCTL_LSB  = 19;
    localparam int ADDRLOADCTL_W    = 3;
    localparam int STACK_INC_BIT    = 22;
    localparam int STACK_DEC_BIT    = 23;
    localparam int STEP_RESETN_BIT  = 24;
    localparam int STEP_EXTN_BIT    = 25;
    localparam int CLK_HALT_BIT     = 26;
    localparam int CLK_BRK_BIT      = 27;
    localparam int ACALC_SIGNED_BIT = 28;

    // Active-low step controls parked inactive, every other field off.
    localparam logic [31:0] DEFAULT_IDLE_CW = 32'h0300_0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BREAK  = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ustep_counter.sv
// Microstep counter with extended-page bit and sticky wrap-around error flag.
module ustep_counter #(
    parameter int STEP_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              adv_i,
    input  logic              rst_step_i,
    input  logic              ext_jump_i,
    output logic [STEP_W-1:0] step_o,
    output logic              ext_o,
    output logic              wrap_err_o
);

    logic [STEP_W-1:0] step_q, step_d;
    logic              ext_q, ext_d;
    logic              err_q, err_d;

    always_comb begin
        step_d = step_q;
        ext_d  = ext_q;
        err_d  = err_q;
        if (adv_i) begin
            if (rst_step_i) begin
                step_d = '0;
                ext_d  = 1'b0;
            end else if (ext_jump_i) begin
                step_d = '0;
                ext_d  = 1'b1;
            end else begin
                // Running off the end of a page keeps the page but flags the microcode bug.
                step_d = step_q + STEP_W'(1);
                if (&step_q) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step_q <= '0;
            ext_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            step_q <= step_d;
            ext_q  <= ext_d;
            err_q  <= err_d;
        end
    end

    assign step_o     = step_q;
    assign ext_o      = ext_q;
    assign wrap_err_o = err_q;

endmodule

// File: rtl/cword_sequencer.sv
// Registered microcode sequencer: forms the ROM address, latches the control
// word, splits it into fields and runs the RUN/BREAK/HALTED control flow.
module cword_sequencer
    import cword_pkg::*;
#(
    parameter int                OPCODE_W = 8,
    parameter int                FLAGS_W  = 4,
    parameter int                STEP_W   = 3,
    parameter int                CW_W     = 32,
    parameter logic [CW_W-1:0]   IDLE_CW  = CW_W'(DEFAULT_IDLE_CW)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [OPCODE_W-1:0]                  opcode,
    input  logic [FLAGS_W-1:0]                   flags,
    output logic [1+FLAGS_W+OPCODE_W+STEP_W-1:0] uaddr,
    input  logic [CW_W-1:0]                      rom_data,
    input  logic                                 step_mode,
    input  logic                                 step_req,
    input  logic                                 resume,
    output logic [3:0]                           outctl,
    output logic [3:0]                           loadctl,
    output logic [1:0]                           alu_arg_l,
    output logic [2:0]                           alu_arg_r,
    output logic                                 alu_alt,
    output logic                                 flags_calc,
    output logic                                 carry,
    output logic [2:0]                           addroutctl,
    output logic [2:0]                           addrloadctl,
    output logic                                 stack_inc,
    output logic                                 stack_dec,
    output logic                                 acalc_signed,
    output logic [STEP_W-1:0]                    step,
    output logic                                 ext,
    output logic                                 halted,
    output logic                                 in_break,
    output logic                                 step_wrap_err
);

    seq_state_t        state_q, state_d;
    logic [CW_W-1:0]   cw_q, cw_d;
    logic [STEP_W-1:0] step_q;
    logic              ext_q;
    logic              adv;
    logic              unused_cw;

    assign adv = (state_q == RUN) && (!step_mode || step_req);

    ustep_counter #(
        .STEP_W(STEP_W)
    ) u_ustep (
        .clk_i      (clk),
        .rst_i      (reset),
        .adv_i      (adv),
        .rst_step_i (~rom_data[STEP_RESETN_BIT]),
        .ext_jump_i (~rom_data[STEP_EXTN_BIT]),
        .step_o     (step_q),
        .ext_o      (ext_q),
        .wrap_err_o (step_wrap_err)
    );

    // The halting/breaking word is latched once so its other fields still execute.
    always_comb begin
        state_d = state_q;
        cw_d    = IDLE_CW;
        case (state_q)
            RUN: begin
                if (adv) begin
                    cw_d = rom_data;
                    if (rom_data[CLK_HALT_BIT])     state_d = HALTED;
                    else if (rom_data[CLK_BRK_BIT]) state_d = BREAK;
                end
            end
            BREAK: begin
                if (resume) state_d = RUN;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cw_q    <= IDLE_CW;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
        end
    end

    assign uaddr    = {ext_q, flags, opcode, step_q};
    assign step     = step_q;
    assign ext      = ext_q;
    assign halted   = (state_q == HALTED);
    assign in_break = (state_q == BREAK);

    assign outctl       = cw_q[OUTCTL_LSB +: OUTCTL_W];
    assign loadctl      = cw_q[LOADCTL_LSB +: LOADCTL_W];
    assign alu_arg_l    = cw_q[ALU_ARG_L_LSB +: ALU_ARG_L_W];
    assign alu_arg_r    = cw_q[ALU_ARG_R_LSB +: ALU_ARG_R_W];
    assign alu_alt      = cw_q[ALU_ALT_BIT];
    assign flags_calc   = cw_q[FLAGS_CALC_BIT];
    assign carry        = cw_q[CARRY_BIT];
    assign addroutctl   = cw_q[ADDROUTCTL_LSB +: ADDROUTCTL_W];
    assign addrloadctl  = cw_q[ADDRLOADCTL_LSB +: ADDRLOADCTL_W];
    assign stack_inc    = cw_q[STACK_INC_BIT];
    assign stack_dec    = cw_q[STACK_DEC_BIT];
    assign acalc_signed = cw_q[ACALC_SIGNED_BIT];

    // Sequencing bits and any bits above the field map only matter on the ROM side.
    assign unused_cw = ^{cw_q[CLK_BRK_BIT:STEP_RESETN_BIT], cw_q >> (ACALC_SIGNED_BIT + 1)};

endmodule

// File: tb/tb_cword_sequencer.sv
// Directed bench for cword_sequencer with a small table-driven microcode ROM.
module tb_cword_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  opcode = 8'h12;
    logic [3:0]  flags = 4'hA;
    logic [15:0] uaddr;
    logic [31:0] rom_data;
    logic        step_mode = 1'b0;
    logic        step_req = 1'b0;
    logic        resume = 1'b0;
    logic [3:0]  outctl, loadctl;
    logic [1:0]  alu_arg_l;
    logic [2:0]  alu_arg_r, addroutctl, addrloadctl, step;
    logic        alu_alt, flags_calc, carry, stack_inc, stack_dec, acalc_signed;
    logic        ext, halted, in_break, step_wrap_err;

    logic [31:0] rom_tbl [16];
    logic [24:0] fields;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // ROM content depends only on {ext, step}; opcode and flags stay constant.
    assign rom_data = rom_tbl[{uaddr[15], uaddr[2:0]}];
    assign fields = {acalc_signed, stack_dec, stack_inc, addrloadctl, addroutctl,
                     carry, flags_calc, alu_alt, alu_arg_r, alu_arg_l, loadctl, outctl};

    cword_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .flags(flags), .uaddr(uaddr),
        .rom_data(rom_data), .step_mode(step_mode), .step_req(step_req), .resume(resume),
        .outctl(outctl), .loadctl(loadctl), .alu_arg_l(alu_arg_l), .alu_arg_r(alu_arg_r),
        .alu_alt(alu_alt), .flags_calc(flags_calc), .carry(carry), .addroutctl(addroutctl),
        .addrloadctl(addrloadctl), .stack_inc(stack_inc), .stack_dec(stack_dec),
        .acalc_signed(acalc_signed), .step(step), .ext(ext), .halted(halted),
        .in_break(in_break), .step_wrap_err(step_wrap_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] w);
        return {7'd0, w[28], w[23:0]};
    endfunction

    function automatic logic [31:0] addr_of(input logic e, input logic [2:0] s);
        return {16'd0, e, 4'hA, 8'h12, s};
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 16; i++) rom_tbl[i] = 32'h0300_0000 | 32'(i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] w1 [4];
    logic [31:0] exp_w [6];
    logic [31:0] exp_s [6];
    logic        exp_e [6];
    int          adv_n;

    initial begin
        w1[0] = 32'h1300_A5C1;
        w1[1] = 32'h0355_5A32;
        w1[2] = 32'h03AA_0F03;
        w1[3] = 32'h02FF_FF04;

        // Free run with step reset at step 3
        fill_rom();
        for (int i = 0; i < 4; i++) rom_tbl[i] = w1[i];
        do_reset();
        check_eq("rst_step", 32'(step), 32'd0);
        check_eq("rst_ext", 32'(ext), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_break", 32'(in_break), 32'd0);
        check_eq("rst_err", 32'(step_wrap_err), 32'd0);
        check_eq("rst_fields", 32'(fields), 32'd0);
        check_eq("rst_uaddr", 32'(uaddr), addr_of(1'b0, 3'd0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("run_fields", 32'(fields), fld(w1[i % 4]));
            check_eq("run_step", 32'(step), 32'((i + 1) % 4));
            check_eq("run_uaddr", 32'(uaddr), addr_of(1'b0, 3'((i + 1) % 4)));
        end

        // Extended page jump and return
        fill_rom();
        rom_tbl[2]  = 32'h0100_0003;
        rom_tbl[8]  = 32'h0300_0005;
        rom_tbl[9]  = 32'h0200_0006;
        exp_w[0] = rom_tbl[0]; exp_w[1] = rom_tbl[1]; exp_w[2] = rom_tbl[2];
        exp_w[3] = rom_tbl[8]; exp_w[4] = rom_tbl[9]; exp_w[5] = rom_tbl[0];
        exp_s[0] = 1; exp_s[1] = 2; exp_s[2] = 0; exp_s[3] = 1; exp_s[4] = 0; exp_s[5] = 1;
        exp_e[0] = 0; exp_e[1] = 0; exp_e[2] = 1; exp_e[3] = 1; exp_e[4] = 0; exp_e[5] = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("ext_fields", 32'(fields), fld(exp_w[i]));
            check_eq("ext_step", 32'(step), exp_s[i]);
            check_eq("ext_ext", 32'(ext), 32'(exp_e[i]));
            check_eq("ext_uaddr", 32'(uaddr), addr_of(exp_e[i], exp_s[i][2:0]));
        end

        // Break at step 1, then resume
        fill_rom();
        rom_tbl[1] = 32'h0B00_0002;
        do_reset();
        @(negedge clk);
        check_eq("brk_s0_fields", 32'(fields), fld(rom_tbl[0]));
        @(negedge clk);
        check_eq("brk_word_fields", 32'(fields), fld(32'h0B00_0002));
        check_eq("brk_in_break", 32'(in_break), 32'd1);
        check_eq("brk_step", 32'(step), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("brk_idle_fields", 32'(fields), 32'd0);
            check_eq("brk_hold_step", 32'(step), 32'd2);
            check_eq("brk_hold", 32'(in_break), 32'd1);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check_eq("resume_in_break", 32'(in_break), 32'd0);
        check_eq("resume_fields", 32'(fields), 32'd0);
        check_eq("resume_step", 32'(step), 32'd2);
        @(negedge clk);
        check_eq("resume_s2_fields", 32'(fields), fld(rom_tbl[2]));
        check_eq("resume_s2_step", 32'(step), 32'd3);

        // Halt and break in one word that also resets the step
        fill_rom();
        rom_tbl[1] = 32'h0E00_0002;
        do_reset();
        repeat (2) @(negedge clk);
        check_eq("halt_fields", 32'(fields), fld(32'h0E00_0002));
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_not_break", 32'(in_break), 32'd0);
        check_eq("halt_step_reset", 32'(step), 32'd0);
        for (int i = 0; i < 20; i++) begin
            resume   = (i % 2 == 0);
            step_req = (i % 2 == 1);
            @(negedge clk);
            check_eq("halt_idle", {7'd0, fields}, 32'd0);
            check_eq("halt_stay", {29'd0, halted, in_break, step == 3'd0}, 32'h5);
        end
        resume   = 1'b0;
        step_req = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("halt_cleared", 32'(halted), 32'd0);
        reset = 1'b0;

        // Single-step mode
        fill_rom();
        for (int i = 0; i < 4; i++) rom_tbl[i] = w1[i];
        step_mode = 1'b1;
        do_reset();
        adv_n = 0;
        for (int i = 0; i < 12; i++) begin
            step_req = (i % 4 == 0);
            @(negedge clk);
            step_req = 1'b0;
            if (i % 4 == 0) begin
                check_eq("ss_adv_fields", 32'(fields), fld(w1[adv_n]));
                adv_n++;
            end else begin
                check_eq("ss_idle_fields", 32'(fields), 32'd0);
            end
            check_eq("ss_step", 32'(step), 32'(adv_n));
        end
        step_mode = 1'b0;

        // Step wrap error and async reset mid-cycle
        fill_rom();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check_eq("wrap_step", 32'(step), 32'(i % 8));
            check_eq("wrap_err", 32'(step_wrap_err), 32'(i >= 8));
            check_eq("wrap_ext", 32'(ext), 32'd0);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_step", 32'(step), 32'd0);
        check_eq("async_err", 32'(step_wrap_err), 32'd0);
        check_eq("async_fields", 32'(fields), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cword_sequencer.md
Name: cword_sequencer

Overview:
- Microcode sequencer that replaces the bare control-word field split with a registered, stateful control unit.
- Forms the microcode address from opcode, flags, extended-page bit and step counter, and latches the returned 32-bit control word into a pipeline register.
- Splits the latched word into bus, ALU, address-bus and misc fields.
- Handles step reset, extended-page jump, halt, break/resume and single-step mode.

Parameters:
- OPCODE_W, 8, instruction register width in the microcode address
- FLAGS_W, 4, CPU flags width in the microcode address
- STEP_W, 3, microstep counter width
- CW_W, 32, control word width; must be >= 29
- IDLE_CW, 32'h0300_0000, word loaded while stalled (active-low bits 24/25 inactive, everything else off)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  OPCODE_W  current instruction register value
- flags  in  FLAGS_W  current CPU flags
- uaddr  out  1+FLAGS_W+OPCODE_W+STEP_W  microcode address {ext_q, flags, opcode, step_q}, combinational
- rom_data  in  CW_W  microcode word for uaddr, combinational (asynchronous ROM)
- step_mode  in  1  1 = single-step
- step_req  in  1  single-cycle pulse, advance one microstep in single-step mode
- resume  in  1  single-cycle pulse, leave BREAK
- outctl  out  4  cw_q[3:0]
- loadctl  out  4  cw_q[7:4]
- alu_arg_l  out  2  cw_q[9:8]
- alu_arg_r  out  3  cw_q[12:10]
- alu_alt  out  1  cw_q[13]
- flags_calc  out  1  cw_q[14]
- carry  out  1  cw_q[15]
- addroutctl  out  3  cw_q[18:16]
- addrloadctl  out  3  cw_q[21:19]
- stack_inc  out  1  cw_q[22]
- stack_dec  out  1  cw_q[23]
- acalc_signed  out  1  cw_q[28]
- step  out  STEP_W  step_q
- ext  out  1  ext_q
- halted  out  1  state == HALTED
- in_break  out  1  state == BREAK
- step_wrap_err  out  1  sticky step counter overflow

Behaviour:
- Reset (async) values:
  - step_q=0, ext_q=0, state=RUN
  - cw_q=IDLE_CW, so all field outputs decode to IDLE_CW
  - step_wrap_err=0
- Advance edge: a rising edge in RUN where step_mode=0, or where step_mode=1 and step_req=1. On an advance edge:
  - cw_q <= rom_data; fields for step n are valid in the cycle after step_q==n, giving latency 1.
  - Step update, evaluated on rom_data:
    - rom_data[24]==0 (step_resetn active): step_q <= 0, ext_q <= 0.
    - Else rom_data[25]==0 (step_extn active): step_q <= 0, ext_q <= 1.
    - Else step_q <= step_q+1, modulo 2^STEP_W.
    - If step_q is at all-ones and wraps, ext_q is unchanged and step_wrap_err <= 1. The flag clears only on reset.
  - State update:
    - rom_data[26] (clk_halt) set: state <= HALTED.
    - Else rom_data[27] (clk_brk) set: state <= BREAK.
    - Halt wins over break.
- Non-advance edge in RUN (single-step, no step_req): cw_q <= IDLE_CW; step_q and ext_q hold.
- HALTED: cw_q <= IDLE_CW on every edge; step_q and ext_q frozen; exits only on reset. resume and step_req are ignored.
- BREAK: cw_q <= IDLE_CW; step_q and ext_q frozen at their already-advanced values. resume=1 -> state <= RUN; fetching continues at the frozen step on the next advance edge. resume is ignored outside BREAK.
- The halting or breaking word itself is latched for exactly one cycle, so its other fields still execute.
- The step_resetn/step_extn decision on the halting or breaking word is still applied before freezing.
- Simultaneous step_resetn and step_extn: reset wins.
- step_req while step_mode=0: ignored.
- Reset asserted mid-operation: all registers return to reset values immediately, independent of clk.

Decomposition:
- Package cword_pkg holds:
  - field LSB/width localparams for every control word field (including step_resetn=24, step_extn=25, clk_halt=26, clk_brk=27)
  - enum seq_state_t {RUN, BREAK, HALTED}
  - DEFAULT_IDLE_CW
- One sub-module, ustep_counter. It contains step_q, ext_q and step_wrap_err with inputs adv, rst_step, ext_jump; it is parametrised by STEP_W.
- Field split and state machine stay in the top module.

Test Plan:
- Free run, opcode=8'h12, ROM words with step_resetn active at step 3 -> step sequence 0,1,2,3,0; outctl equals each word's [3:0] one cycle later; uaddr low bits track step.
- step_extn active at step 2, then step_resetn active at ext=1/step 1 -> ext goes 0->1, step goes 2->0->1->0, ext returns to 0.
- clk_brk word at step 1 -> in_break=1 next cycle, cw_q=IDLE_CW, step holds at 2. Pulse resume -> step 2's word latched on the following advance edge.
- clk_halt and clk_brk set in the same word -> halted=1, in_break=0. Outputs stay IDLE_CW for 20 cycles despite resume/step_req; reset clears halted.
- step_mode=1 with three step_req pulses spaced 4 cycles -> exactly three advances; outputs are IDLE_CW between pulses.
- STEP_W=3, no step reset for 9 advances -> step wraps 7->0, step_wrap_err=1 and stays set. Async reset asserted mid-cycle -> immediate return to reset values.
